// File: rtl/rps_pkg.sv
// Shared constants and helpers for the rotating-priority requester.
package rps_pkg;
    localparam int NREQ  = 4;
    localparam int CNT_W = 3;
    localparam int ID_W  = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [ID_W-1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/rps_requester_if.sv
// Request/grant bundle between requester (master) and arbiter (slave).
interface rps_requester_if import rps_pkg::*; ();
    logic [NREQ-1:0] req;
    logic            en;
    logic [NREQ-1:0] gnt;

    modport master (output req, output en, input gnt);
    modport slave  (input req, input en, output gnt);
endinterface

// File: rtl/rps_req_chan.sv
// One request line: saturating pending-event counter.
module rps_req_chan import rps_pkg::*; (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic take,
    output logic req,
    output logic full,
    output logic ovf_evt
);
    logic [CNT_W-1:0] pend;

    assign req  = (pend != '0);
    assign full = (pend == CNT_MAX);
    // A same-cycle take frees a slot, so a push at max is not lost.
    assign ovf_evt = push & full & ~take;

    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= '0;
        end else if (push && !take && !full) begin
            pend <= pend + 1'b1;
        end else if (take && !push) begin
            pend <= pend - 1'b1;
        end
    end
endmodule

// File: rtl/rps_requester.sv
// Requester agent: queues events per line, checks and consumes grants.
module rps_requester import rps_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   push,
    input  logic              enable,
    rps_requester_if.master   arb,
    output logic              served_valid,
    output logic [ID_W-1:0]   served_id,
    output logic [NREQ-1:0]   full,
    output logic              overflow,
    output logic              proto_err,
    output logic [7:0]        grant_total
);
    logic [NREQ-1:0] req_w;
    logic [NREQ-1:0] take;
    logic [NREQ-1:0] ovf_evt;
    logic            en_w;
    logic            gnt_any;
    logic            gnt_one;
    logic            legal;
    logic            illegal;

    assign en_w    = enable & (|req_w);
    assign arb.req = req_w;
    assign arb.en  = en_w;

    assign gnt_any = (arb.gnt != '0);
    assign gnt_one = gnt_any &&
                     ((arb.gnt & (arb.gnt - 1'b1)) == '0);
    assign legal   = gnt_one && en_w &&
                     ((arb.gnt & ~req_w) == '0);
    assign illegal = gnt_any & ~legal;
    assign take    = {NREQ{legal}} & arb.gnt;

    for (genvar i = 0; i < NREQ; i++) begin : g_chan
        rps_req_chan u_chan (
            .clock   (clock),
            .reset   (reset),
            .push    (push[i]),
            .take    (take[i]),
            .req     (req_w[i]),
            .full    (full[i]),
            .ovf_evt (ovf_evt[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            served_valid <= 1'b0;
            served_id    <= '0;
            overflow     <= 1'b0;
            proto_err    <= 1'b0;
            grant_total  <= '0;
        end else begin
            served_valid <= legal;
            served_id    <= legal ? oh2idx(arb.gnt) : '0;
            overflow     <= overflow | (|ovf_evt);
            proto_err    <= proto_err | illegal;
            if (legal) grant_total <= grant_total + 8'd1;
        end
    end
endmodule

// File: doc/rps_requester.md
Name: rps_requester

Overview:
- Requester-side agent for the rotating-priority arbiter. Drives the arbiter's req and en inputs and consumes its gnt output.
- Queues pending request events per line in saturating counters. Asserts req[i] while line i has work pending.
- On each legal grant, retires one pending event and reports the served line one cycle later.
- Checks the grant stream against protocol rules: one-hot only, and only on a line that is requesting.

Parameters:
- NREQ, 4, number of request lines; fixed at 4 to match the 4-line arbiter.
- CNT_W, 3, pending-counter width per line; maximum pending events = 2^CNT_W-1 = 7.
- ID_W, 2, width of the served-line index; must equal log2(NREQ).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- push  input  NREQ  one-cycle event per line: add one pending request on that line.
- enable  input  1  upstream permission to be granted.
- gnt  input  NREQ  grant vector from the arbiter; combinational response to req in the same cycle.
- req  output  NREQ  to arbiter; req[i] = (pend[i] != 0). Combinational from registered state only.
- en  output  1  to arbiter; en = enable & (|req).
- served_valid  output  1  registered pulse: a legal grant was consumed in the previous cycle.
- served_id  output  ID_W  index of the line granted in the previous cycle. Valid only with served_valid, otherwise 0.
- full  output  NREQ  full[i] = (pend[i] == 2^CNT_W-1).
- overflow  output  1  sticky: a push arrived while the line was full.
- proto_err  output  1  sticky: an illegal grant was observed.
- grant_total  output  8  count of legal grants consumed; wraps 255 -> 0.

Behaviour:
- Reset: all pend = 0, so req = 0, en = 0, full = 0. served_valid = 0, served_id = 0, overflow = 0, proto_err = 0, grant_total = 0.
- Reset asserted mid-operation discards every pending event. The clear takes effect on the next edge, regardless of push or gnt in that cycle.
- Legal grant in a cycle, all of the following must hold:
  - gnt is one-hot;
  - req[i] = 1 for the granted line i;
  - en = 1.
- On a legal grant:
  - pend[i] decrements at the next edge;
  - served_valid = 1 and served_id = i at the next edge;
  - grant_total increments.
- Illegal grant, any of the following:
  - gnt has more than one bit set;
  - gnt[i] = 1 with req[i] = 0;
  - gnt != 0 with en = 0.
- On an illegal grant: proto_err sets at the next edge and stays set until reset. No counter changes from the grant; served_valid = 0 for that cycle.
- gnt = 0 is always legal and is a no-op.
- push[i] with pend[i] < max increments pend[i]. Push on several lines in the same cycle is allowed; each line is independent.
- push[i] while pend[i] = max: the event is dropped, overflow sets sticky, pend[i] stays at max.
- Simultaneous push[i] and legal gnt[i]:
  - pend[i] is unchanged (net zero), served_valid still asserts;
  - at max, this is not an overflow, because the grant frees a slot in the same cycle.
- Simultaneous push[i] and illegal grant: the push is processed normally; the grant is ignored.
- Latency:
  - push at edge k -> req visible after edge k, so the arbiter can grant in cycle k+1;
  - grant in cycle k -> served_valid after edge k;
  - back-to-back grants on the same line in consecutive cycles are supported.
- The last pending event granted -> req[i] drops after that edge. There is no extra request cycle.
- enable low holds all pending events; req stays asserted and en = 0. Any grant during this time is illegal.
- Sticky flags clear only on reset.

Decomposition:
- Shared package rps_pkg:
  - NREQ, ID_W, CNT_W constants;
  - the one-hot-to-index function.
- Sub-module rps_req_chan, instantiated NREQ times:
  - inputs: clock, reset, push, take (legal grant for this line);
  - outputs: req, full, ovf_evt;
  - contents: one saturating up/down counter.
- Top level holds the grant legality check, the served register, the sticky flags and grant_total.

Test Plan:
- Reset then idle, enable = 1 -> req = 0000, en = 0, all flags 0, grant_total = 0.
- push = 0001 for 3 cycles, then gnt = 0001 for 3 consecutive cycles:
  - req[0] stays 1 through the 3rd grant, then drops;
  - served_valid for 3 cycles with served_id = 0;
  - grant_total = 3.
- push[2] for 8 cycles with no grant -> full[2] = 1 after the 7th push, overflow = 1 after the 8th, pend[2] = 7. Then push[2] and gnt = 0100 in the same cycle -> pend stays 7, no further overflow event.
- Illegal grants from a clean state:
  - gnt = 0011 with req = 0011 -> proto_err = 1, no decrement;
  - separately, gnt = 1000 with req[3] = 0 -> proto_err = 1.
- enable = 0 with req = 0010 -> en = 0; gnt = 0010 -> proto_err = 1 and pend[1] unchanged.
- Assert reset with pend = {2,0,5,1} and a grant active -> next cycle all counters 0, req = 0, served_valid = 0, flags cleared.
